pixel_frame_rx: RTL and testbench

PIXEL_FRAME_RX -- requirements
Module: pixel_frame_rx

---
 rtl/pixel_frame_rx.sv | 193 +++++++++++++++++++
 tb/tb_pixel_frame_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_rx.sv
// pixel_frame_rx: receives one ROWS x COLUMNS frame of 8-bit pixels over an
// AXI-Stream style link into a local buffer, holds it until the consumer
// acknowledges, and flags short/long frames. Optional per-frame min/max/sum
// statistics are built when PIXEL_FRAME_STATS_EN is defined; otherwise the
// stats outputs are tied to zero.
`timescale 1ns/1ps
module pixel_frame_rx #(
    parameter  int ROWS    = 4,
    parameter  int COLUMNS = 4,
    localparam int PIXELS  = ROWS * COLUMNS,
    localparam int AW      = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    localparam int SW      = 8 + AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [7:0]    s_tdata,
    input  logic          s_tlast,
    output logic          frame_valid,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_short,
    output logic          err_long,
    output logic [15:0]   frame_cnt,
    output logic [7:0]    pix_min,
    output logic [7:0]    pix_max,
    output logic [SW-1:0] pix_sum
);

    typedef enum logic [1:0] {RECV, HOLD, DROP} state_t;

    localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_cnt, wr_cnt_nxt;
    logic          beat;
    logic          wr_en;
    logic          good;
    logic          short_nxt;
    logic          long_nxt;
    logic [7:0]    mem [0:PIXELS-1];
    logic [7:0]    rd_val;

    assign beat = s_tvalid && s_tready;

    // Next-state and framing decisions, driven only by accepted beats and ack.
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        wr_en      = 1'b0;
        good       = 1'b0;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        case (state)
            RECV: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (wr_cnt == LAST) begin
                        wr_cnt_nxt = '0;
                        if (s_tlast) begin
                            good      = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            long_nxt  = 1'b1;
                            state_nxt = DROP;
                        end
                    end else if (s_tlast) begin
                        short_nxt  = 1'b1;
                        wr_cnt_nxt = '0;
                    end else begin
                        wr_cnt_nxt = wr_cnt + AW'(1);
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_nxt = RECV;
                end
            end
            DROP: begin
                if (beat && s_tlast) begin
                    state_nxt  = RECV;
                    wr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = RECV;
                wr_cnt_nxt = '0;
            end
        endcase
    end

    // Control registers; ready/valid are registered copies decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RECV;
            s_tready    <= 1'b1;
            frame_valid <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            wr_cnt      <= '0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            s_tready    <= (state_nxt != HOLD);
            frame_valid <= (state_nxt == HOLD);
            err_short   <= short_nxt;
            err_long    <= long_nxt;
            wr_cnt      <= wr_cnt_nxt;
            if (good) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Frame buffer write port; only accepted RECV beats write, so HOLD leaves it intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt] <= s_tdata;
        end
    end

    generate
        if (PIXELS == (1 << AW)) begin : g_rd_full
            assign rd_val = mem[rd_addr];
        end else begin : g_rd_partial
            assign rd_val = (rd_addr < AW'(PIXELS)) ? mem[rd_addr] : 8'h00;
        end
    endgenerate

    // Registered read port, one cycle of latency, usable in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= rd_val;
        end
    end

`ifdef PIXEL_FRAME_STATS_EN
    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [7:0]    run_min, run_max, min_nxt, max_nxt;
    logic [SW-1:0] run_sum, sum_nxt;

    // Running stats including the current beat; wr_cnt==0 marks the first beat of a frame.
    always_comb begin
        min_nxt = min8(run_min, s_tdata);
        max_nxt = max8(run_max, s_tdata);
        sum_nxt = run_sum + SW'(s_tdata);
        if (wr_cnt == '0) begin
            min_nxt = min8(8'hFF, s_tdata);
            max_nxt = max8(8'h00, s_tdata);
            sum_nxt = SW'(s_tdata);
        end
    end

    // Accumulators advance on every beat written into the buffer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            run_min <= min_nxt;
            run_max <= max_nxt;
            run_sum <= sum_nxt;
        end
    end

    // Published stats latch on the beat that completes a good frame and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_min <= 8'h00;
            pix_max <= 8'h00;
            pix_sum <= '0;
        end else if (good) begin
            pix_min <= min_nxt;
            pix_max <= max_nxt;
            pix_sum <= sum_nxt;
        end
    end
`else
    assign pix_min = 8'h00;
    assign pix_max = 8'h00;
    assign pix_sum = '0;
`endif

endmodule

// File: tb/tb_pixel_frame_rx.sv
// Directed, table-driven bench for pixel_frame_rx (4x4 frames).
`timescale 1ns/1ps
module tb_pixel_frame_rx;

    localparam int ROWS    = 4;
    localparam int COLUMNS = 4;
    localparam int PIXELS  = 16;
    localparam int AW      = 4;
    localparam int SW      = 12;
    localparam bit STATS_ON =
`ifdef PIXEL_FRAME_STATS_EN
        1'b1;
`else
        1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          s_tvalid;
    logic          s_tready;
    logic [7:0]    s_tdata;
    logic          s_tlast;
    logic          frame_valid;
    logic          frame_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          err_short;
    logic          err_long;
    logic [15:0]   frame_cnt;
    logic [7:0]    pix_min;
    logic [7:0]    pix_max;
    logic [SW-1:0] pix_sum;

    pixel_frame_rx #(.ROWS(ROWS), .COLUMNS(COLUMNS)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .err_short  (err_short),
        .err_long   (err_long),
        .frame_cnt  (frame_cnt),
        .pix_min    (pix_min),
        .pix_max    (pix_max),
        .pix_sum    (pix_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int            kind;
        int            n;
        bit            toggle;
        bit            exp_fv;
        int            exp_short;
        int            exp_long;
        int            long_beat;
        int            exp_cnt;
        logic [7:0]    mn;
        logic [7:0]    mx;
        logic [SW-1:0] sm;
    } vec_t;

    vec_t vecs [7];
    int   passed = 0;
    int   total  = 0;
    int   n_short, n_long, long_at;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'hAA;
            2:       return 8'(255 - 3 * i);
            default: return 8'(i * 17);
        endcase
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_err(input int beat_idx);
        if (err_short) n_short++;
        if (err_long) begin
            n_long++;
            long_at = beat_idx;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last);
        int w = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        while (!s_tready && w < 50) begin
            idle();
            w++;
        end
        if (!s_tready) begin
            total++;
            $display("FAIL ready_timeout: s_tready=0 after %0d cycles, required 1", w);
        end
        idle();
        // junk on the bus while invalid must be ignored
        s_tvalid = 1'b0;
        s_tdata  = 8'h5A;
        s_tlast  = 1'b1;
    endtask

    task automatic send_frame(input int kind, input int n, input bit toggle);
        n_short = 0;
        n_long  = 0;
        long_at = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(pat(kind, i), (i == n - 1));
            sample_err(i + 1);
            if (toggle) begin
                idle();
                sample_err(i + 1);
            end
        end
        idle();
        sample_err(n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd1);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_err_short"}, 32'(err_short), 32'd0);
        chk({tag, "_err_long"}, 32'(err_long), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_pix_min"}, 32'(pix_min), 32'd0);
        chk({tag, "_pix_max"}, 32'(pix_max), 32'd0);
        chk({tag, "_pix_sum"}, 32'(pix_sum), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = 8'h00;
        s_tlast   = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = '0;
        repeat (2) idle();
        chk_reset_outputs("reset");
        rst = 1'b0;
        idle();

        // ack outside HOLD must be ignored
        frame_ack = 1'b1;
        idle();
        frame_ack = 1'b0;
        idle();
        chk("ack_in_recv_ready", 32'(s_tready), 32'd1);
        chk("ack_in_recv_fv", 32'(frame_valid), 32'd0);

        //           kind n  tgl fv sh lg lb cnt min    max    sum
        vecs[0] = '{0, 16, 0, 1, 0, 0, 0, 1, 8'd0,   8'd15,  12'd120};
        vecs[1] = '{0, 16, 1, 1, 0, 0, 0, 2, 8'd0,   8'd15,  12'd120};
        vecs[2] = '{2, 10, 0, 0, 1, 0, 0, 2, 8'd0,   8'd15,  12'd120};
        vecs[3] = '{3, 16, 0, 1, 0, 0, 0, 3, 8'd0,   8'd255, 12'd2040};
        vecs[4] = '{0, 20, 0, 0, 0, 1, 16, 3, 8'd0,  8'd255, 12'd2040};
        vecs[5] = '{1, 16, 0, 1, 0, 0, 0, 4, 8'hAA,  8'hAA,  12'd2720};
        vecs[6] = '{2, 16, 1, 1, 0, 0, 0, 5, 8'd210, 8'd255, 12'd3720};

        for (int r = 0; r < 7; r++) begin
            send_frame(vecs[r].kind, vecs[r].n, vecs[r].toggle);
            chk($sformatf("v%0d_err_short_cnt", r), 32'(n_short), 32'(vecs[r].exp_short));
            chk($sformatf("v%0d_err_long_cnt", r), 32'(n_long), 32'(vecs[r].exp_long));
            if (vecs[r].exp_long != 0)
                chk($sformatf("v%0d_err_long_beat", r), 32'(long_at), 32'(vecs[r].long_beat));
            chk($sformatf("v%0d_frame_valid", r), 32'(frame_valid), 32'(vecs[r].exp_fv));
            chk($sformatf("v%0d_s_tready", r), 32'(s_tready), 32'(!vecs[r].exp_fv));
            chk($sformatf("v%0d_frame_cnt", r), 32'(frame_cnt), 32'(vecs[r].exp_cnt));
            chk($sformatf("v%0d_pix_min", r), 32'(pix_min), STATS_ON ? 32'(vecs[r].mn) : 32'd0);
            chk($sformatf("v%0d_pix_max", r), 32'(pix_max), STATS_ON ? 32'(vecs[r].mx) : 32'd0);
            chk($sformatf("v%0d_pix_sum", r), 32'(pix_sum), STATS_ON ? 32'(vecs[r].sm) : 32'd0);
            if (vecs[r].exp_fv) begin
                // transmitter keeps pushing during HOLD: must be stalled
                s_tvalid = 1'b1;
                s_tdata  = 8'h77;
                s_tlast  = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    idle();
                    chk($sformatf("v%0d_hold_ready", r), 32'(s_tready), 32'd0);
                end
                s_tvalid = 1'b0;
                chk($sformatf("v%0d_hold_cnt", r), 32'(frame_cnt), 32'(vecs[r].exp_cnt));
                for (int a = 0; a < PIXELS; a++) begin
                    rd_addr = AW'(a);
                    if (a > 0)
                        chk($sformatf("v%0d_rd_latency_%0d", r, a), 32'(rd_data), 32'(pat(vecs[r].kind, a - 1)));
                    idle();
                    chk($sformatf("v%0d_rd_%0d", r, a), 32'(rd_data), 32'(pat(vecs[r].kind, a)));
                end
                frame_ack = 1'b1;
                idle();
                frame_ack = 1'b0;
                chk($sformatf("v%0d_ack_ready", r), 32'(s_tready), 32'd1);
                chk($sformatf("v%0d_ack_fv", r), 32'(frame_valid), 32'd0);
            end
        end

        // reset after 7 beats of a frame abandons it silently
        for (int i = 0; i < 7; i++) send_beat(pat(0, i), 1'b0);
        rst = 1'b1;
        idle();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        idle();
        chk("midrst_post_err_short", 32'(err_short), 32'd0);
        chk("midrst_post_err_long", 32'(err_long), 32'd0);
        send_frame(3, 16, 1'b0);
        chk("midrst_short_cnt", 32'(n_short), 32'd0);
        chk("midrst_fv", 32'(frame_valid), 32'd1);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("midrst_pix_max", 32'(pix_max), STATS_ON ? 32'd255 : 32'd0);
        chk("midrst_pix_sum", 32'(pix_sum), STATS_ON ? 32'd2040 : 32'd0);
        rd_addr = AW'(5);
        idle();
        chk("midrst_rd_5", 32'(rd_data), 32'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
